// File: rtl/player_ship.sv
// player_ship: ship movement, firing cooldown, lives/explosion/respawn state machine and sprite rendering.
module player_ship #(
  parameter int SCREEN_WIDTH  = 640,
  parameter int SHIP_WIDTH    = 60,
  parameter int SHIP_HEIGHT   = 30,
  parameter int H_OFFSET      = 10,
  parameter int V_OFFSET      = 10,
  parameter int STEP          = 20,
  parameter int LIVES         = 3,
  parameter int FIRE_COOLDOWN = 8,
  parameter int EXPLODE_TICKS = 30,
  parameter int RESPAWN_TICKS = 60,
  parameter int RECT_WIDTH    = 9,
  parameter int BACKGROUND    = 0,
  parameter int SPACESHIP     = 1,
  parameter int EXPLOSION     = 6,
  parameter int NONE          = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       left,
  input  logic       right,
  input  logic       fire,
  input  logic       hit,
  input  logic [9:0] hPos,
  input  logic [9:0] vPos,
  output logic [9:0] gunPosition,
  output logic [2:0] color,
  output logic       fireReq,
  output logic [2:0] lives,
  output logic [1:0] state,
  output logic       gameOver
);
  typedef enum logic [1:0] {ALIVE = 2'd0, EXPLODING = 2'd1, RESPAWN = 2'd2, DEAD = 2'd3} state_t;
  localparam logic [10:0] HW     = 11'(SHIP_WIDTH / 2);
  localparam logic [10:0] MIN_X  = 11'(H_OFFSET + SHIP_WIDTH / 2);
  localparam logic [10:0] MAX_X  = 11'(SCREEN_WIDTH - H_OFFSET - SHIP_WIDTH / 2);
  localparam logic [10:0] CENTER = 11'(SCREEN_WIDTH / 2);
  localparam logic [10:0] STEP_W = 11'(STEP);
  localparam logic [10:0] RW     = 11'(RECT_WIDTH);
  localparam logic [10:0] V_TOP  = 11'(V_OFFSET);
  localparam logic [10:0] V_BOT  = 11'(V_OFFSET + SHIP_HEIGHT);
  localparam logic [7:0]  FC     = 8'(FIRE_COOLDOWN);
  localparam logic [7:0]  ET     = 8'(EXPLODE_TICKS);
  localparam logic [7:0]  RT     = 8'(RESPAWN_TICKS);
  localparam logic [2:0]  LV     = 3'(LIVES);
  localparam logic [2:0]  C_BG   = 3'(BACKGROUND);
  localparam logic [2:0]  C_SHIP = 3'(SPACESHIP);
  localparam logic [2:0]  C_EXP  = 3'(EXPLOSION);
  localparam logic [2:0]  C_NONE = 3'(NONE);

  state_t      state_q, state_d;
  logic [10:0] gun_q, gun_d;
  logic [2:0]  lives_q, lives_d;
  logic [7:0]  cool_q, cool_d;
  logic [7:0]  tick_q, tick_d;
  logic        fire_q, fire_d;
  logic [2:0]  color_q, color_d;
  logic        hit_now, live, last, in_box, ship;
  logic [10:0] up, dn, h, v, dx;
  logic [2:0]  drawn, boom;

  always_comb begin
    hit_now = hit && state_q == ALIVE;
    live = state_q == ALIVE || state_q == RESPAWN;
    fire_d = enable && fire && state_q == ALIVE && cool_q == 8'd0 && !hit_now;
    up = gun_q + STEP_W > MAX_X ? MAX_X : gun_q + STEP_W;
    dn = gun_q < MIN_X + STEP_W ? MIN_X : gun_q - STEP_W;
    last = enable && tick_q <= 8'd1;
    state_d = state_q;
    gun_d = enable && live && (left ^ right) && !hit_now ? (right ? up : dn) : gun_q;
    lives_d = lives_q;
    tick_d = tick_q;
    cool_d = fire_d ? FC : enable && cool_q != 8'd0 ? cool_q - 8'd1 : cool_q;
    if (hit_now) begin
      state_d = EXPLODING;
      lives_d = lives_q - 3'd1;
      cool_d = 8'd0;
      tick_d = ET;
    end else if (enable && state_q == EXPLODING) begin
      tick_d = last ? (lives_q == 3'd0 ? 8'd0 : RT) : tick_q - 8'd1;
      state_d = !last ? EXPLODING : lives_q == 3'd0 ? DEAD : RESPAWN;
      gun_d = last && lives_q != 3'd0 ? CENTER : gun_q;
    end else if (enable && state_q == RESPAWN) begin
      tick_d = last ? 8'd0 : tick_q - 8'd1;
      state_d = last ? ALIVE : RESPAWN;
    end
    // Sprite: side rectangles, top bar and a downward-pointing triangle around the gun.
    h = {1'b0, hPos};
    v = {1'b0, vPos};
    in_box = v > V_TOP && v < V_BOT && h + HW > gun_q && h < gun_q + HW;
    dx = h > gun_q ? h - gun_q : gun_q - h;
    ship = h + HW < gun_q + RW || gun_q + HW < h + RW || v == V_TOP + 11'd1 || dx < V_BOT - v;
    drawn = ship ? C_SHIP : C_BG;
    boom = hPos[0] ^ vPos[0] ^ tick_q[1] ? C_EXP : C_BG;
    color_d = !in_box ? C_NONE : state_q == ALIVE ? drawn : state_q == RESPAWN ? (tick_q[2] ? C_NONE : drawn) : state_q == EXPLODING ? boom : C_NONE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ALIVE;
      gun_q <= CENTER;
      lives_q <= LV;
      cool_q <= 8'd0;
      tick_q <= 8'd0;
      fire_q <= 1'b0;
      color_q <= C_NONE;
    end else begin
      state_q <= state_d;
      gun_q <= gun_d;
      lives_q <= lives_d;
      cool_q <= cool_d;
      tick_q <= tick_d;
      fire_q <= fire_d;
      color_q <= color_d;
    end
  end

  assign gunPosition = gun_q[9:0];
  assign color = color_q;
  assign fireReq = fire_q;
  assign lives = lives_q;
  assign state = state_q;
  assign gameOver = state_q == DEAD;
endmodule

// File: doc/player_ship.md
PLAYER_SHIP -- requirements
Module: player_ship

Interface
REQ-001 SHALL have parameter SCREEN_WIDTH, 640, horizontal pixel count.
REQ-002 SHALL have parameter SHIP_WIDTH, 60; SHIP_HEIGHT, 30; ship bounding box in pixels.
REQ-003 SHALL have parameter H_OFFSET, 10; V_OFFSET, 10; screen margins in pixels.
REQ-004 SHALL have parameter STEP, 20, pixels moved per enable tick.
REQ-005 SHALL have parameter LIVES, 3 (1..7), lives at reset.
REQ-006 SHALL have parameter FIRE_COOLDOWN, 8; EXPLODE_TICKS, 30; RESPAWN_TICKS, 60; all in enable ticks, each 1..255.
REQ-007 SHALL have parameter RECT_WIDTH, 9, side-rectangle width in pixels.
REQ-008 SHALL have parameters BACKGROUND 0, SPACESHIP 1, EXPLOSION 6, NONE 7; 3-bit colour codes.
REQ-009 SHALL have port clk, in, 1, system clock; all state changes on its rising edge.
REQ-010 SHALL have port reset, in, 1, synchronous active-high reset.
REQ-011 SHALL have ports enable (in, 1, one-cycle frame tick), left (in, 1), right (in, 1), fire (in, 1), hit (in, 1, one-cycle hit pulse from collision logic).
REQ-012 SHALL have ports hPos and vPos, in, 10 each, current pixel coordinates.
REQ-013 SHALL have ports gunPosition (out, 10, ship centre x), color (out, 3), fireReq (out, 1, one-cycle shot request), lives (out, 3), state (out, 2), gameOver (out, 1).

Function
REQ-014 SHALL define MIN_X = H_OFFSET+SHIP_WIDTH/2 and MAX_X = SCREEN_WIDTH-H_OFFSET-SHIP_WIDTH/2; gunPosition SHALL always stay within [MIN_X, MAX_X].
REQ-015 SHALL implement states ALIVE=0, EXPLODING=1, RESPAWN=2, DEAD=3, all visible on state.
REQ-016 SHALL move only on enable in ALIVE or RESPAWN: right alone -> min(gunPosition+STEP, MAX_X); left alone -> max(gunPosition-STEP, MIN_X); both or neither -> no move.
REQ-017 SHALL compute all position arithmetic at 11 bits or wider, so there is no wrap-around at either edge.
REQ-018 SHALL assert fireReq for exactly one cycle when enable & fire & state==ALIVE & cooldown==0, and then load cooldown with FIRE_COOLDOWN.
REQ-019 SHALL decrement a non-zero cooldown on each enable tick in every state.
REQ-020 SHALL, on hit in ALIVE: decrement lives, clear cooldown, load tick counter with EXPLODE_TICKS, and enter EXPLODING on the next cycle.
REQ-021 SHALL ignore hit in EXPLODING, RESPAWN and DEAD.
REQ-022 SHALL decrement the tick counter on enable in EXPLODING; at 0: if lives==0, enter DEAD; otherwise enter RESPAWN, load RESPAWN_TICKS and set gunPosition to SCREEN_WIDTH/2.
REQ-023 SHALL decrement the tick counter on enable in RESPAWN; at 0, enter ALIVE.
REQ-024 SHALL hold DEAD until reset, with gameOver=1 only in DEAD.
REQ-025 SHALL give hit precedence over same-cycle movement and fire; a hit cycle does not move the ship and does not assert fireReq.
REQ-026 SHALL register color with 1-cycle latency relative to hPos/vPos.
REQ-027 SHALL output color=NONE outside the box V_OFFSET<vPos<V_OFFSET+SHIP_HEIGHT, gunPosition-SHIP_WIDTH/2<hPos<gunPosition+SHIP_WIDTH/2, and in DEAD.
REQ-028 SHALL output SPACESHIP inside the box in ALIVE when any of these holds: hPos is within RECT_WIDTH of either box edge; vPos==V_OFFSET+1; |hPos-gunPosition| < V_OFFSET+SHIP_HEIGHT-vPos. Otherwise it SHALL output BACKGROUND.
REQ-029 SHALL, in RESPAWN, draw as ALIVE while tick counter bit 2 is 0, and output NONE while it is 1 (blink).
REQ-030 SHALL, in EXPLODING, output EXPLOSION inside the box where hPos[0]^vPos[0]^counter[1] is 1, and BACKGROUND otherwise.

Reset
REQ-031 SHALL, on reset, set gunPosition=SCREEN_WIDTH/2 (320), lives=LIVES, state=ALIVE, cooldown=0, tick counter=0, fireReq=0, gameOver=0 and color=NONE, overriding all other inputs that cycle.
REQ-032 SHALL honour reset from any state, including mid-explosion and DEAD.

Verification
REQ-033 SHALL verify movement: reset, then 20 enable ticks with right=1 -> gunPosition 340,360,...,600, then holds at 600; left and right together -> no change.
REQ-034 SHALL verify fire: fire held with enable every cycle -> fireReq pulses with an interval of 9 enable ticks; fireReq is never asserted outside ALIVE.
REQ-035 SHALL verify hit: hit in ALIVE -> lives 3->2, state=1; after 30 ticks state=2 and gunPosition=320; after 60 more ticks state=0; a hit during RESPAWN -> lives unchanged.
REQ-036 SHALL verify game over: three hits, each after its full ALIVE recovery -> state=3 after the third explosion, gameOver=1, color=NONE everywhere; then reset -> lives=3, state=0.
REQ-037 SHALL verify render: gunPosition=320, pixel (hPos=295,vPos=20) -> SPACESHIP one cycle later; (320,20) -> SPACESHIP; (310,38) -> BACKGROUND; (400,20) -> NONE.
REQ-038 SHALL verify simultaneous events: hit, enable, right and fire all in one cycle -> no move, no fireReq, state=EXPLODING.
